// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared FSM state type and parameter helpers for serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit digit_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && ((width % digit) == 0);
  endfunction

  // A single-step adder still needs a one-bit counter.
  function automatic int cnt_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder_slice.sv
`default_nettype none
// ============================================================================
// Module      : half_adder / full_adder_slice
// Description : Half-adder cell and the DIGIT-bit ripple slice built from it.
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module full_adder_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ctop
);
  logic [DIGIT:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    logic w_s1, w_c1, w_c2;
    half_adder u_ha0 (.i_x(i_a[i]), .i_y(i_b[i]), .o_s(w_s1),     .o_c(w_c1));
    half_adder u_ha1 (.i_x(w_s1),   .i_y(w_c[i]), .o_s(o_sum[i]), .o_c(w_c2));
    assign w_c[i+1] = w_c1 | w_c2;
  end

  assign o_cout = w_c[DIGIT];
  // Carry entering the slice's top bit; feeds the signed-overflow check.
  assign o_ctop = w_c[DIGIT-1];
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Digit-serial adder, DIGIT bits per cycle, start/busy/done.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(STEPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

  if (!digit_ok(WIDTH, DIGIT)) begin : g_bad_param
    $fatal(1, "serial_adder: DIGIT must divide WIDTH");
  end

  state_t             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_a, r_b, r_acc, r_sum;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry, r_cout, r_ovf;
  logic               w_accept, w_last;
  logic [DIGIT-1:0]   w_dsum;
  logic               w_dcout, w_dctop;
  logic [WIDTH-1:0]   w_acc_shift;

  full_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_dsum),
    .o_cout (w_dcout),
    .o_ctop (w_dctop)
  );

  // New digits enter at the MSB so the accumulator is aligned after STEPS shifts.
  if (STEPS > 1) begin : g_acc_multi
    assign w_acc_shift = {w_dsum, r_acc[WIDTH-1:DIGIT]};
  end else begin : g_acc_single
    assign w_acc_shift = w_dsum;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_accept    = start;
        w_state_nxt = start ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (r_state == RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_carry <= w_dcout;
        r_acc   <= w_acc_shift;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
      if (w_last) begin
        r_sum  <= w_acc_shift;
        r_cout <= w_dcout;
        r_ovf  <= w_dctop ^ w_dcout;
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule
`default_nettype wire
